// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, control bundle,
// instruction field positions and the ID/EX pipeline register layout.
package isa_pkg;

    localparam int REG_W  = 5;
    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    localparam int IMM_W  = 16;

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000,
        OP_ADDI = 6'b000001,
        OP_SUB  = 6'b000010,
        OP_SUBI = 6'b000011,
        OP_MUL  = 6'b000100,
        OP_MULI = 6'b000101,
        OP_OR   = 6'b000110,
        OP_ORI  = 6'b000111,
        OP_AND  = 6'b001000,
        OP_ANDI = 6'b001001,
        OP_XOR  = 6'b001010,
        OP_XORI = 6'b001011,
        OP_LDW  = 6'b001100,
        OP_STW  = 6'b001101,
        OP_BZ   = 6'b001110,
        OP_BEQ  = 6'b001111,
        OP_JR   = 6'b010000,
        OP_HALT = 6'b010001,
        OP_NOP  = 6'b111111
    } opcode_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic halt;
    } ctrl_t;

    typedef struct packed {
        logic             valid;
        logic [5:0]       opcode;
        logic [31:0]      rs_val;
        logic [31:0]      rt_val;
        logic [31:0]      imm;
        logic [REG_W-1:0] dest;
        ctrl_t            ctrl;
        logic [31:0]      pc;
    } id_ex_t;

endpackage

// File: rtl/reg_file.sv
// Register file: NREGS x XLEN, two async read ports, one sync write port,
// async active-low clear. Ports: clk, rst, we/waddr/wdata, raddr_a/b -> rdata_a/b.
module reg_file #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/inst_d.sv
// Instruction-decode stage: decodes, reads the register file, drives ID/EX.
// Ports: clk, rst (async low), instruction/pc_in, stall/flush, wb_* write-back,
// rs/rt/rd_f_id + id_dest/reg_write_f_id to fetch, ex_* ID/EX outputs, halted.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data into rs/rt.
module inst_d
    import isa_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  instruction,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             stall,
    input  logic             flush,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_dest,
    input  logic [XLEN-1:0]  wb_data,
    output logic [REG_W-1:0] rs_f_id,
    output logic [REG_W-1:0] rt_f_id,
    output logic [REG_W-1:0] rd_f_id,
    output logic [REG_W-1:0] id_dest,
    output logic             reg_write_f_id,
    output logic             ex_valid,
    output logic [5:0]       ex_opcode,
    output logic [XLEN-1:0]  ex_rs_val,
    output logic [XLEN-1:0]  ex_rt_val,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REG_W-1:0] ex_dest,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_branch,
    output logic             ex_halt,
    output logic [XLEN-1:0]  ex_pc,
    output logic             halted
);

    logic [5:0]       op_raw;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  rf_a;
    logic [XLEN-1:0]  rf_b;
    logic [XLEN-1:0]  rs_val;
    logic [XLEN-1:0]  rt_val;
    logic [XLEN-1:0]  imm;
    opcode_e          op;
    ctrl_t            ctrl;
    logic [REG_W-1:0] dest;
    id_ex_t           ex_q;
    logic             halted_q;

    assign op_raw = instruction[OP_LSB +: 6];
    assign rs     = instruction[RS_LSB +: REG_W];
    assign rt     = instruction[RT_LSB +: REG_W];
    assign rd     = instruction[RD_LSB +: REG_W];
    assign imm    = {{(XLEN-IMM_W){instruction[IMM_W-1]}},
                     instruction[IMM_W-1:0]};

    assign rs_f_id = rs;
    assign rt_f_id = rt;
    assign rd_f_id = rd;

    reg_file #(
        .NREGS (NREGS),
        .XLEN  (XLEN),
        .AW    (REG_W)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_dest),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rf_a),
        .raddr_b (rt),
        .rdata_b (rf_b)
    );

`ifdef ID_WB_BYPASS_EN
    assign rs_val = (wb_we && wb_dest == rs) ? wb_data : rf_a;
    assign rt_val = (wb_we && wb_dest == rt) ? wb_data : rf_b;
`else
    assign rs_val = rf_a;
    assign rt_val = rf_b;
`endif

    // Unrecognised opcodes fall through to the NOP defaults.
    always_comb begin
        op   = OP_NOP;
        ctrl = '0;
        dest = '0;
        unique case (op_raw)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
                op             = opcode_e'(op_raw);
                ctrl.reg_write = 1'b1;
                dest           = rd;
            end
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
                op             = opcode_e'(op_raw);
                ctrl.reg_write = 1'b1;
                dest           = rt;
            end
            OP_LDW: begin
                op             = OP_LDW;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                dest           = rt;
            end
            OP_STW: begin
                op             = OP_STW;
                ctrl.mem_write = 1'b1;
            end
            OP_BZ, OP_BEQ, OP_JR: begin
                op          = opcode_e'(op_raw);
                ctrl.branch = 1'b1;
            end
            OP_HALT: begin
                op        = OP_HALT;
                ctrl.halt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q     <= '0;
            halted_q <= 1'b0;
        end else if (flush || halted_q || stall) begin
            ex_q <= '0;
        end else begin
            ex_q.valid  <= 1'b1;
            ex_q.opcode <= op;
            ex_q.rs_val <= rs_val;
            ex_q.rt_val <= rt_val;
            ex_q.imm    <= imm;
            ex_q.dest   <= dest;
            ex_q.ctrl   <= ctrl;
            ex_q.pc     <= pc_in;
            if (ctrl.halt) halted_q <= 1'b1;
        end
    end

    assign ex_valid       = ex_q.valid;
    assign ex_opcode      = ex_q.opcode;
    assign ex_rs_val      = ex_q.rs_val;
    assign ex_rt_val      = ex_q.rt_val;
    assign ex_imm         = ex_q.imm;
    assign ex_dest        = ex_q.dest;
    assign ex_reg_write   = ex_q.ctrl.reg_write;
    assign ex_mem_read    = ex_q.ctrl.mem_read;
    assign ex_mem_write   = ex_q.ctrl.mem_write;
    assign ex_branch      = ex_q.ctrl.branch;
    assign ex_halt        = ex_q.ctrl.halt;
    assign ex_pc          = ex_q.pc;
    assign halted         = halted_q;
    assign id_dest        = ex_q.dest;
    assign reg_write_f_id = ex_q.valid & ex_q.ctrl.reg_write;

endmodule
